neuron_layer_ctrl: RTL and testbench
====================================

NEURON_LAYER_CTRL -- requirements
Module: neuron_layer_ctrl

Interface
REQ-001 SHALL have parameter N_IN, default 8: inputs (weights) per neuron; legal range 2..256.
REQ-002 SHALL have parameter N_NEU, default 4: neurons per layer; legal range 1..256.
REQ-003 SHALL have parameter IAW, default max(1,clog2(N_IN)): input-address width.
REQ-004 SHALL have parameter NAW, default max(1,clog2(N_NEU)): neuron-address width.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1: request one full layer pass; sampled only in IDLE.
REQ-008 SHALL have port mem_rdy, input, 1: input/weight memory data valid for the current addresses.
REQ-009 SHALL have port in_addr, output, IAW: input/weight index of the current neuron.
REQ-010 SHALL have port neu_addr, output, NAW: current neuron index.
REQ-011 SHALL have port ld_x, output, 1: load strobe to the 8-bit input register.
REQ-012 SHALL have port ld_w, output, 1: load strobe to the 8-bit weight register.
REQ-013 SHALL have port acc_clr, output, 1: synchronous clear of the 21-bit accumulator register.
REQ-014 SHALL have port acc_en, output, 1: load strobe to the accumulator (accumulator <= accumulator + x*w).
REQ-015 SHALL have port ld_out, output, 1: load strobe to the activation output register.
REQ-016 SHALL have port out_wr, output, 1: write strobe for the result at neu_addr.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at pass completion.

Function
REQ-019 SHALL implement the states IDLE, CLR, FETCH, MAC, ACT, WRITE and DONE.
REQ-020 IDLE SHALL go to CLR when start=1 and stay in IDLE otherwise; all strobes low.
REQ-021 CLR SHALL assert acc_clr for exactly one cycle and then go to FETCH; in_addr is 0 in CLR.
REQ-022 FETCH SHALL hold in_addr and neu_addr stable and wait indefinitely while mem_rdy=0.
REQ-023 When mem_rdy=1 in FETCH, ld_x and ld_w SHALL be asserted in that same cycle (combinational on mem_rdy) and the next state SHALL be MAC.
REQ-024 MAC SHALL assert acc_en for one cycle.
REQ-025 MAC SHALL go to ACT if in_addr = N_IN-1; otherwise in_addr increments and the next state is FETCH.
REQ-026 ACT SHALL assert ld_out for one cycle and then go to WRITE.
REQ-027 WRITE SHALL assert out_wr for one cycle with neu_addr equal to the index of the neuron just finished.
REQ-028 From WRITE, if neu_addr = N_NEU-1 the next state SHALL be DONE; otherwise neu_addr increments, in_addr returns to 0 and the next state is CLR.
REQ-029 DONE SHALL assert done for one cycle, clear both counters to 0 and return to IDLE.
REQ-030 start SHALL be ignored in all states except IDLE; start held high SHALL cause a new pass to begin on the cycle after DONE.
REQ-031 At most one of acc_clr, acc_en, ld_out and out_wr SHALL be high in any cycle; ld_x and ld_w SHALL only be high in FETCH.
REQ-032 With mem_rdy tied high, done SHALL be high in cycle N_NEU*(2*N_IN+3)+1, counted from the edge that samples start as cycle 0.
REQ-033 Counters SHALL never exceed N_IN-1 and N_NEU-1; no wrap-around within a pass.
REQ-034 N_NEU=1 SHALL go directly from WRITE to DONE.

Reset
REQ-035 rst=1 SHALL immediately force state IDLE, in_addr=0, neu_addr=0 and all strobes, busy and done to 0, regardless of clk.
REQ-036 Reset during any state SHALL abandon the pass without producing out_wr or done; after reset release, the next start SHALL run a complete fresh pass.

Verification
REQ-037 N_IN=4, N_NEU=2, mem_rdy=1, one-cycle start -> exactly 8 acc_en, 2 acc_clr, 2 ld_out, 2 out_wr (neu_addr 0 then 1), done in cycle 23, busy low afterwards.
REQ-038 mem_rdy held low for 5 cycles in the first FETCH -> no ld_x, ld_w or acc_en during the stall, addresses stable, done delayed by exactly 5 cycles.
REQ-039 start pulsed again while busy -> ignored, exactly one done; start held high continuously -> back-to-back passes with CLR one cycle after DONE.
REQ-040 rst asserted mid-pass in MAC (in_addr=2, neu_addr=1) -> outputs zero asynchronously, no done; a subsequent start produces a full 23-cycle pass.
REQ-041 N_IN=2, N_NEU=1 boundary -> sequence CLR, FETCH, MAC, FETCH, MAC, ACT, WRITE, DONE with done in cycle 8.
REQ-042 Every run -> assertion that acc_clr, acc_en, ld_out and out_wr are mutually exclusive and that in_addr < N_IN and neu_addr < N_NEU.

Source files
------------

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully-connected neuron layer: steps through every input/weight
// pair of every neuron, driving the MAC datapath strobes and writing each result.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// CLR   | clear accumulator for the current neuron
// FETCH | wait for mem_rdy, then load x and w registers
// MAC   | accumulate x*w, advance input index
// ACT   | load activation output register
// WRITE | write result for neu_addr
// DONE  | one-cycle completion pulse, counters cleared
module neuron_layer_ctrl #(
    parameter int N_IN  = 8,
    parameter int N_NEU = 4,
    parameter int IAW   = (N_IN > 2) ? $clog2(N_IN) : 1,
    parameter int NAW   = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mem_rdy,
    output logic [IAW-1:0] in_addr,
    output logic [NAW-1:0] neu_addr,
    output logic           ld_x,
    output logic           ld_w,
    output logic           acc_clr,
    output logic           acc_en,
    output logic           ld_out,
    output logic           out_wr,
    output logic           busy,
    output logic           done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FETCH = 3'd2,
        MAC   = 3'd3,
        ACT   = 3'd4,
        WRITE = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [IAW-1:0] IN_LAST  = IAW'(N_IN - 1);
    localparam logic [NAW-1:0] NEU_LAST = NAW'(N_NEU - 1);

    state_t         state_q, state_d;
    logic [IAW-1:0] in_addr_q, in_addr_d;
    logic [NAW-1:0] neu_addr_q, neu_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_addr_q  <= '0;
            neu_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            in_addr_q  <= in_addr_d;
            neu_addr_q <= neu_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_addr_d  = in_addr_q;
        neu_addr_d = neu_addr_q;
        ld_x       = 1'b0;
        ld_w       = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        ld_out     = 1'b0;
        out_wr     = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLR;
            end
            CLR: begin
                acc_clr   = 1'b1;
                in_addr_d = '0;
                state_d   = FETCH;
            end
            FETCH: begin
                // Loads follow mem_rdy combinationally so data is captured the cycle it is valid.
                if (mem_rdy) begin
                    ld_x    = 1'b1;
                    ld_w    = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_en = 1'b1;
                if (in_addr_q == IN_LAST) begin
                    state_d = ACT;
                end else begin
                    in_addr_d = in_addr_q + IAW'(1);
                    state_d   = FETCH;
                end
            end
            ACT: begin
                ld_out  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                out_wr = 1'b1;
                if (neu_addr_q == NEU_LAST) begin
                    state_d = DONE;
                end else begin
                    neu_addr_d = neu_addr_q + NAW'(1);
                    in_addr_d  = '0;
                    state_d    = CLR;
                end
            end
            DONE: begin
                done       = 1'b1;
                in_addr_d  = '0;
                neu_addr_d = '0;
                // A held start chains straight into the next pass without an IDLE cycle.
                state_d    = start ? CLR : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign in_addr  = in_addr_q;
    assign neu_addr = neu_addr_q;

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Scoreboard bench: dut 0 is N_IN=4/N_NEU=2, dut 1 is the N_IN=2/N_NEU=1 boundary case.
module tb_neuron_layer_ctrl;

    typedef struct {
        int dut;
        int is_done;
        int neu;
        int cyc;
        int n_en;
        int n_clr;
        int n_out;
        int busy_after;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic       mem_rdy_a, mem_rdy_b;
    logic [1:0] in_addr_a;
    logic [0:0] in_addr_b;
    logic [0:0] neu_addr_a;
    logic [0:0] neu_addr_b;
    logic       ld_x [2];
    logic       ld_w [2];
    logic       acc_clr [2];
    logic       acc_en [2];
    logic       ld_out [2];
    logic       out_wr [2];
    logic       busy [2];
    logic       done [2];

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    int   cnt_en [2];
    int   cnt_clr [2];
    int   cnt_out [2];
    int   pend [2];
    int   pend_busy [2];

    neuron_layer_ctrl #(.N_IN(4), .N_NEU(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_rdy(mem_rdy_a),
        .in_addr(in_addr_a), .neu_addr(neu_addr_a),
        .ld_x(ld_x[0]), .ld_w(ld_w[0]), .acc_clr(acc_clr[0]), .acc_en(acc_en[0]),
        .ld_out(ld_out[0]), .out_wr(out_wr[0]), .busy(busy[0]), .done(done[0])
    );

    neuron_layer_ctrl #(.N_IN(2), .N_NEU(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_rdy(mem_rdy_b),
        .in_addr(in_addr_b), .neu_addr(neu_addr_b),
        .ld_x(ld_x[1]), .ld_w(ld_w[1]), .acc_clr(acc_clr[1]), .acc_en(acc_en[1]),
        .ld_out(ld_out[1]), .out_wr(out_wr[1]), .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d cyc=%0d: got %0d, expected %0d", name, d, cyc, act, exp);
        end
    endfunction

    // Expected events of one pass: writes at the end of each neuron, then done.
    task automatic push_pass(input int d, input int s, input int stall, input int busy_after);
        int nin, nn, p;
        nin = (d == 0) ? 4 : 2;
        nn  = (d == 0) ? 2 : 1;
        p   = 2 * nin + 3;
        for (int n = 0; n < nn; n++)
            sb.push_back('{d, 0, n, s + (n + 1) * p + stall, 0, 0, 0, 0});
        sb.push_back('{d, 1, 0, s + nn * p + 1 + stall, nn * nin, nn, nn, busy_after});
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("scoreboard_drained", -1, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   ia, na, lim_i, lim_n, rdy;
            exp_t e;
            ia    = (d == 0) ? int'(in_addr_a) : int'(in_addr_b);
            na    = (d == 0) ? int'(neu_addr_a) : int'(neu_addr_b);
            rdy   = (d == 0) ? int'(mem_rdy_a) : int'(mem_rdy_b);
            lim_i = (d == 0) ? 4 : 2;
            lim_n = (d == 0) ? 2 : 1;
            if (rst) begin
                cnt_en[d]  = 0;
                cnt_clr[d] = 0;
                cnt_out[d] = 0;
                pend[d]    = 0;
            end else begin
                if (pend[d] != 0) begin
                    chk("busy_after_done", d, int'(busy[d]), pend_busy[d]);
                    pend[d] = 0;
                end
                chk("strobe_mutex", d,
                    int'((int'(acc_clr[d]) + int'(acc_en[d]) + int'(ld_out[d]) + int'(out_wr[d])) <= 1), 1);
                chk("in_addr_range", d, int'(ia < lim_i), 1);
                chk("neu_addr_range", d, int'(na < lim_n), 1);
                chk("ld_x_eq_ld_w", d, int'(ld_x[d]), int'(ld_w[d]));
                if (ld_x[d]) chk("ld_x_needs_mem_rdy", d, rdy, 1);
                if (acc_en[d])  cnt_en[d]++;
                if (acc_clr[d]) cnt_clr[d]++;
                if (ld_out[d])  cnt_out[d]++;
                if (out_wr[d]) begin
                    if (sb.size() == 0) chk("unexpected_out_wr", d, sb.size(), 1);
                    else begin
                        e = sb.pop_front();
                        chk("out_wr_dut", d, d, e.dut);
                        chk("out_wr_kind", d, e.is_done, 0);
                        chk("out_wr_neu_addr", d, na, e.neu);
                        chk("out_wr_cycle", d, cyc, e.cyc);
                    end
                end
                if (done[d]) begin
                    if (sb.size() == 0) chk("unexpected_done", d, sb.size(), 1);
                    else begin
                        e = sb.pop_front();
                        chk("done_dut", d, d, e.dut);
                        chk("done_kind", d, e.is_done, 1);
                        chk("done_cycle", d, cyc, e.cyc);
                        chk("acc_en_count", d, cnt_en[d], e.n_en);
                        chk("acc_clr_count", d, cnt_clr[d], e.n_clr);
                        chk("ld_out_count", d, cnt_out[d], e.n_out);
                        chk("in_addr_in_done", d, ia, lim_i - 1);
                        pend[d]      = 1;
                        pend_busy[d] = e.busy_after;
                    end
                    cnt_en[d]  = 0;
                    cnt_clr[d] = 0;
                    cnt_out[d] = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        mem_rdy_a = 1'b1;
        mem_rdy_b = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cnt_en[d] = 0; cnt_clr[d] = 0; cnt_out[d] = 0; pend[d] = 0; pend_busy[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", d, int'(busy[d]), 0);
            chk("reset_done", d, int'(done[d]), 0);
            chk("reset_acc_clr", d, int'(acc_clr[d]), 0);
            chk("reset_out_wr", d, int'(out_wr[d]), 0);
        end
        chk("reset_in_addr", 0, int'(in_addr_a), 0);
        chk("reset_neu_addr", 0, int'(neu_addr_a), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain pass, mem_rdy tied high: done at cycle 23.
        start_a = 1'b1; s = cyc; push_pass(0, s, 0, 0);
        @(negedge clk); start_a = 1'b0;
        drain();

        // Five-cycle stall in the first FETCH.
        mem_rdy_a = 1'b0;
        start_a = 1'b1; s = cyc; push_pass(0, s, 5, 0);
        @(negedge clk); start_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_ld_x", 0, int'(ld_x[0]), 0);
            chk("stall_acc_en", 0, int'(acc_en[0]), 0);
            chk("stall_in_addr", 0, int'(in_addr_a), 0);
            chk("stall_neu_addr", 0, int'(neu_addr_a), 0);
        end
        @(negedge clk); mem_rdy_a = 1'b1;
        drain();

        // start pulses while busy are ignored.
        start_a = 1'b1; s = cyc; push_pass(0, s, 0, 0);
        @(negedge clk); start_a = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        while (cyc < s + 22) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        drain();
        repeat (20) @(negedge clk);

        // start held high: second pass chains from DONE.
        start_a = 1'b1; s = cyc;
        push_pass(0, s, 0, 1);
        push_pass(0, s + 23, 0, 0);
        while (cyc < s + 30) @(negedge clk);
        start_a = 1'b0;
        drain();

        // Reset in MAC with in_addr=2, neu_addr=1, then a fresh pass.
        start_a = 1'b1; s = cyc; push_pass(0, s, 0, 0);
        @(negedge clk); start_a = 1'b0;
        while (cyc < s + 18) @(negedge clk);
        chk("premid_in_addr", 0, int'(in_addr_a), 2);
        chk("premid_neu_addr", 0, int'(neu_addr_a), 1);
        chk("premid_acc_en", 0, int'(acc_en[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_acc_en", 0, int'(acc_en[0]), 0);
        chk("rst_async_busy", 0, int'(busy[0]), 0);
        chk("rst_async_in_addr", 0, int'(in_addr_a), 0);
        chk("rst_async_neu_addr", 0, int'(neu_addr_a), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        start_a = 1'b1; s = cyc; push_pass(0, s, 0, 0);
        @(negedge clk); start_a = 1'b0;
        drain();

        // Boundary: N_IN=2, N_NEU=1, done at cycle 8.
        start_b = 1'b1; s = cyc; push_pass(1, s, 0, 0);
        @(negedge clk); start_b = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
